// File: rtl/upsize_pair_arbiter_pkg.sv
// Shared types and helpers for the beat-pair round-robin arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package upsize_arb_pkg;

    // Pair phase of the shared upsizer input.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } arb_state_t;

    // Width of the optional pad stall counter.
    localparam int PAD_CNT_W = 8;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/upsize_pair_arbiter_rr_pick.sv
// Round-robin selector: first set request after 'last', wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick
    import upsize_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    logic [ID_W:0]   pos;
    logic [ID_W-1:0] sel;

    // Walk offsets from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        sel = '0;
        for (int k = N; k >= 1; k--) begin
            pos = {1'b0, last} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N)) begin
                pos = pos - (ID_W+1)'(N);
            end
            sel = ID_W'(pos);
            if (req[sel]) begin
                any = 1'b1;
                idx = sel;
            end
        end
    end

endmodule

// File: rtl/upsize_pair_arbiter.sv
// Shares one W-to-2W upsizer among N requesters, granting whole beat pairs round-robin.
// Latency: one arbitration cycle from IDLE; pairs follow back-to-back while requests remain.
// Backpressure: in_tready[grant] follows out_tready combinationally; others held at 0.
// Optional pad-beat insertion on a stalled second beat is enabled by UPSIZE_ARB_PAD_EN.
module upsize_pair_arbiter
    import upsize_arb_pkg::*;
#(
    parameter int W = 40,
    parameter int N = 4
`ifdef UPSIZE_ARB_PAD_EN
    ,
    parameter int PAD_TIMEOUT = 8
`endif
    ,
    localparam int ID_W = id_w(N)
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [N*W-1:0]  in_tdata,
    input  logic [N-1:0]    in_tvalid,
    output logic [N-1:0]    in_tready,
    output logic [W-1:0]    out_tdata,
    output logic            out_tvalid,
    input  logic            out_tready,
    output logic [ID_W-1:0] out_tid
`ifdef UPSIZE_ARB_PAD_EN
    ,
    output logic            out_tpad
`endif
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q, last_d;

    logic [W-1:0]    grant_dat;
    logic            grant_vld;
    logic            in_pair;
    logic            hs;
    logic            pad_act;

    logic [ID_W-1:0] pick_last;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;

    assign grant_dat = in_tdata[int'(grant_q)*W +: W];
    assign grant_vld = in_tvalid[grant_q];
    assign in_pair   = (state_q != IDLE);

    // At pair completion the search starts after the requester just served,
    // which is the value 'last' takes on that same edge.
    assign pick_last = (state_q == BEAT1) ? grant_q : last_q;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req  (in_tvalid),
        .last (pick_last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

`ifdef UPSIZE_ARB_PAD_EN
    logic [PAD_CNT_W-1:0] stall_q, stall_d;

    // Once the timeout is reached the pad beat stays asserted until accepted,
    // so a late returning valid cannot retract an offered beat.
    assign pad_act  = (state_q == BEAT1) && (stall_q == PAD_CNT_W'(PAD_TIMEOUT));
    assign out_tpad = pad_act;

    // Count consecutive stalled cycles of the second beat; cleared outside BEAT1.
    always_comb begin
        stall_d = '0;
        if ((state_q == BEAT1) && !hs) begin
            if (pad_act) begin
                stall_d = stall_q;
            end else if (!grant_vld) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign pad_act = 1'b0;
`endif

    // Datapath mux: only the granted requester is visible downstream during a pair.
    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = grant_dat;
        in_tready  = '0;
        if (pad_act) begin
            out_tvalid = 1'b1;
            out_tdata  = '0;
        end else if (in_pair) begin
            out_tvalid         = grant_vld;
            in_tready[grant_q] = out_tready;
        end
    end

    assign out_tid = grant_q;
    assign hs      = out_tvalid & out_tready;

    // Pair sequencing; the grant only moves in IDLE or on the second-beat handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (hs) begin
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (hs) begin
                    last_d = grant_q;
                    if (pick_any) begin
                        grant_d = pick_idx;
                        state_d = BEAT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset makes requester 0 the first winner.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
